memory_access: RTL and testbench

Memory-stage block of the five-stage RISC-V core. It consumes the `ex_to_mem_s` register driven by the execute stage and performs word loads and stores on a variable-latency data-memory port. It registers results into `mem_to_wb_s` for writeback, and it returns the MEM and WB bypass values consumed by execute. While an access is outstanding it stalls the upstream pipeline.

---
 rtl/memory_access.sv | 176 +++++++++++++++++
 tb/tb_memory_access.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: word load/store on a variable-latency data port with timeout
package memory_access_pkg;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  rd;
        logic        mem_read;
    } ex_to_mem_s;

    typedef struct packed {
        logic [31:0] result;
        logic        reg_write;
        logic [4:0]  rd;
    } mem_to_wb_s;

endpackage

module memory_access
    import memory_access_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_to_mem_s  ex_to_mem,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output mem_to_wb_s  mem_to_wb,
    output logic [31:0] bp_mem,
    output logic [31:0] bp_wb,
    output logic        mem_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        rw_q, rw_d;
    logic [4:0]  rd_q, rd_d;
    logic        tout_q, tout_d;
    logic        err_q, err_d;
    mem_to_wb_s  m2wb_q, m2wb_d;
    logic        access;

    assign access = ex_to_mem.mem_read | ex_to_mem.mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            tout_q  <= 1'b0;
            err_q   <= 1'b0;
            m2wb_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
            m2wb_q  <= m2wb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        rw_d     = rw_q;
        rd_d     = rd_q;
        tout_d   = tout_q;
        err_d    = err_q;
        m2wb_d   = m2wb_q;
        stall    = 1'b0;
        dmem_req = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    stall            = 1'b1;
                    addr_d           = {ex_to_mem.alu_result[31:2], 2'b00};
                    wdata_d          = ex_to_mem.write_data;
                    we_d             = ex_to_mem.mem_write;
                    rw_d             = ex_to_mem.reg_write;
                    rd_d             = ex_to_mem.rd;
                    wait_d           = '0;
                    tout_d           = 1'b0;
                    m2wb_d.reg_write = 1'b0;
                    state_d          = REQ;
                end else begin
                    m2wb_d.result    = ex_to_mem.alu_result;
                    m2wb_d.reg_write = ex_to_mem.reg_write;
                    m2wb_d.rd        = ex_to_mem.rd;
                end
            end
            REQ: begin
                stall            = 1'b1;
                dmem_req         = 1'b1;
                m2wb_d.reg_write = 1'b0;
                if (wait_q != WAIT_LIM) wait_d = wait_q + CW'(1);
                // A handshake in the limit cycle still counts as success.
                if (dmem_ready) begin
                    state_d = we_q ? DONE : RESP;
                end else if (wait_q == WAIT_LIM) begin
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = DONE;
                end
            end
            RESP: begin
                stall            = 1'b1;
                m2wb_d.reg_write = 1'b0;
                if (wait_q != WAIT_LIM) wait_d = wait_q + CW'(1);
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end else if (wait_q == WAIT_LIM) begin
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // ex_to_mem still holds the serviced instruction here; only hold registers commit.
                m2wb_d.result    = we_q ? addr_q : rdata_q;
                m2wb_d.reg_write = ~we_q & rw_q & ~tout_q;
                m2wb_d.rd        = rd_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mem_to_wb  = m2wb_q;
    assign bp_mem     = ex_to_mem.alu_result;
    assign bp_wb      = m2wb_q.result;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed and random checks of memory_access against a transaction-level model
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    ex_to_mem_s  ex_to_mem = '0;
    logic        stall, dmem_req, dmem_we, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, bp_mem, bp_wb;
    logic        dmem_ready = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    mem_to_wb_s  mem_to_wb;

    int n_chk = 0;
    int n_fail = 0;
    logic exp_err = 1'b0;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    memory_access #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .ex_to_mem(ex_to_mem), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .mem_to_wb(mem_to_wb), .bp_mem(bp_mem),
        .bp_wb(bp_wb), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // kind: 0 = ALU, 1 = load, 2 = store, 3 = read+write (store)
    task automatic issue(input int kind, input logic [31:0] alu, input logic [31:0] wd,
                         input logic rw, input logic [4:0] rd, input int rdy_w, input int rv_w);
        logic        is_mem, is_st, is_ld, tout, accepted, hs, exp_rw, done;
        logic [31:0] a, exp_res;
        int          need, span, exp_stall, exp_req, stall_n, req_n, rdy_cnt, rv_cnt;
        is_mem = (kind != 0);
        is_st  = (kind >= 2);
        is_ld  = (kind == 1);
        a      = {alu[31:2], 2'b00};
        tout   = 1'b0;
        exp_stall = 0;
        exp_req   = 0;
        if (is_mem) begin
            need      = rdy_w + 1 + (is_ld ? rv_w + 1 : 0);
            tout      = need > MAX_WAIT + 1;
            span      = tout ? MAX_WAIT + 1 : need;
            exp_stall = 1 + span;
            exp_req   = (rdy_w + 1 < MAX_WAIT + 1) ? rdy_w + 1 : MAX_WAIT + 1;
        end
        exp_res = !is_mem ? alu : (is_st ? a : memval(a));
        exp_rw  = rw & (!is_mem | (is_ld & !tout));
        if (tout) exp_err = 1'b1;

        @(negedge clk);
        ex_to_mem.alu_result = alu;
        ex_to_mem.write_data = wd;
        ex_to_mem.mem_write  = (kind >= 2);
        ex_to_mem.mem_read   = (kind == 1) || (kind == 3);
        ex_to_mem.reg_write  = rw;
        ex_to_mem.rd         = rd;
        accepted = 1'b0;
        done     = 1'b0;
        rdy_cnt  = 0;
        rv_cnt   = 0;
        stall_n  = 0;
        req_n    = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            dmem_ready  = 1'b0;
            dmem_rvalid = 1'b0;
            #1;
            if (cyc == 0) chk("bp_mem", bp_mem, alu);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stall_n++;
            if (cyc > 0) chk("bubble_reg_write", 32'(mem_to_wb.reg_write), 32'd0);
            if (dmem_req) begin
                req_n++;
                chk("dmem_addr", dmem_addr, a);
                chk("dmem_we", 32'(dmem_we), 32'(is_st));
                if (is_st) chk("dmem_wdata", dmem_wdata, wd);
                dmem_ready  = (rdy_cnt == rdy_w);
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata  = $urandom;
                rdy_cnt++;
            end else if (accepted) begin
                dmem_rvalid = (rv_cnt == rv_w);
                dmem_ready  = 1'($urandom_range(0, 1));
                dmem_rdata  = dmem_rvalid ? memval(a) : $urandom;
                rv_cnt++;
            end else begin
                dmem_ready  = 1'($urandom_range(0, 1));
                dmem_rvalid = 1'($urandom_range(0, 1));
            end
            hs = dmem_req & dmem_ready;
            @(posedge clk);
            if (hs) accepted = 1'b1;
            @(negedge clk);
        end
        if (!done) chk("stall_bound", 32'd1, 32'd0);
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_cycles", stall_n, exp_stall);
        if (is_mem) chk("req_cycles", req_n, exp_req);
        chk("wb_reg_write", 32'(mem_to_wb.reg_write), 32'(exp_rw));
        chk("wb_rd", 32'(mem_to_wb.rd), 32'(rd));
        if (!(is_ld && tout)) begin
            chk("wb_result", mem_to_wb.result, exp_res);
            chk("bp_wb", bp_wb, exp_res);
        end
        chk("mem_err", 32'(mem_err), 32'(exp_err));
        if (is_st && !tout) mem[a] = wd;
    endtask

    initial begin
        mem[32'h100] = 32'hDEADBEEF;

        // reset, raised mid-cycle
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_wb", {mem_to_wb.result[31:6] ^ mem_to_wb.result[5:0], mem_to_wb.reg_write, mem_to_wb.rd}, 32'd0);
        chk("rst_result", mem_to_wb.result, 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_bp_wb", bp_wb, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU passthrough, zero-wait load, store under backpressure, readback
        issue(0, 32'h1234, 32'h0, 1'b1, 5'd5, 0, 0);
        issue(1, 32'h103, 32'h0, 1'b1, 5'd7, 0, 0);
        issue(2, 32'h40, 32'hA5A5A5A5, 1'b1, 5'd3, 3, 0);
        issue(1, 32'h40, 32'h0, 1'b1, 5'd4, 1, 1);

        // timeout: rvalid never arrives, then an ALU op completes and the flag stays set
        issue(1, 32'h300, 32'h0, 1'b1, 5'd12, 0, 1000);
        issue(0, 32'h55AA, 32'h0, 1'b1, 5'd13, 0, 0);

        // reset while in RESP
        @(negedge clk);
        ex_to_mem = '0;
        ex_to_mem.alu_result = 32'h200;
        ex_to_mem.mem_read   = 1'b1;
        ex_to_mem.reg_write  = 1'b1;
        ex_to_mem.rd         = 5'd9;
        @(negedge clk);
        dmem_ready = 1'b1;
        #1 chk("mid_req_before", 32'(dmem_req), 32'd1);
        @(negedge clk);
        dmem_ready = 1'b0;
        #1 chk("mid_in_resp", {30'd0, stall, dmem_req}, 32'd2);
        #1 rst = 1'b1;
        #1;
        exp_err = 1'b0;
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_commit", 32'(mem_to_wb.reg_write), 32'd0);
        chk("mid_rst_err", 32'(mem_err), 32'd0);
        chk("mid_rst_stall_idle", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        ex_to_mem = '0;
        issue(1, 32'h100, 32'h0, 1'b1, 5'd10, 0, 2);

        // back-to-back mix
        issue(0, 32'h11, 32'h0, 1'b1, 5'd1, 0, 0);
        issue(1, 32'h44, 32'h0, 1'b1, 5'd2, 0, 0);
        issue(0, 32'h22, 32'h0, 1'b1, 5'd3, 0, 0);
        issue(2, 32'h48, 32'h12345678, 1'b0, 5'd4, 0, 0);
        issue(0, 32'h33, 32'h0, 1'b1, 5'd5, 0, 0);

        // random mix; loads and stores share a small address window
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [31:0] al;
            k  = $urandom_range(0, 3);
            al = (k == 0) ? $urandom : ($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            issue(k, al, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
